// File: rtl/pc_upstream_packer_if.sv
// Upstream report channels (spike-filter, heartbeat) and the PC-bound word channel.
// slave is the packer's view; master is the surrounding fabric (sources and PC sink).
interface pc_upstream_packer_if #(
  parameter int Ncode      = 8,
  parameter int Nconf      = 16,
  parameter int N_SF_filts = 10,
  parameter int N_SF_state = 27,
  parameter int N_TM_time  = 48
);
  logic                    SF_out_v;
  logic                    SF_out_a;
  logic [N_SF_filts-1:0]   SF_out_filt_idx;
  logic [N_SF_state-1:0]   SF_out_state;
  logic                    TM_hb_v;
  logic                    TM_hb_a;
  logic [N_TM_time-1:0]    TM_hb_time;
  logic                    PC_out_v;
  logic                    PC_out_a;
  logic [Ncode+Nconf-1:0]  PC_out_d;

  modport slave (
    input  SF_out_v, SF_out_filt_idx, SF_out_state,
    input  TM_hb_v, TM_hb_time,
    input  PC_out_a,
    output SF_out_a, TM_hb_a,
    output PC_out_v, PC_out_d
  );

  modport master (
    output SF_out_v, SF_out_filt_idx, SF_out_state,
    output TM_hb_v, TM_hb_time,
    output PC_out_a,
    input  SF_out_a, TM_hb_a,
    input  PC_out_v, PC_out_d
  );
endinterface

// File: rtl/pc_upstream_packer.sv
// Serialises spike-filter and heartbeat reports into {code, payload} chunks for the PC link,
// least-significant chunk first, with round-robin arbitration between the two sources.
module pc_upstream_packer #(
  parameter int Nconf      = 16,
  parameter int Ncode      = 8,
  parameter int N_SF_filts = 10,
  parameter int N_SF_state = 27,
  parameter int N_TM_time  = 48,
  parameter logic [Ncode-3:0] SF_src_id = 6'h10,
  parameter logic [Ncode-3:0] HB_src_id = 6'h11
) (
  input logic                  clk,
  input logic                  reset,
  pc_upstream_packer_if.slave  bus
);

  localparam int SF_W       = N_SF_filts + N_SF_state;
  localparam int SF_CHUNKS  = (SF_W + Nconf - 1) / Nconf;
  localparam int HB_CHUNKS  = (N_TM_time + Nconf - 1) / Nconf;
  localparam int MAX_CHUNKS = (SF_CHUNKS > HB_CHUNKS) ? SF_CHUNKS : HB_CHUNKS;
  localparam int MSG_W      = MAX_CHUNKS * Nconf;
  localparam int CNT_W      = (MAX_CHUNKS > 4) ? $clog2(MAX_CHUNKS) : 2;

  localparam logic [CNT_W-1:0] SF_LAST = CNT_W'(SF_CHUNKS - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_CHUNKS - 1);

  typedef enum logic {IDLE, SEND} state_t;
  typedef enum logic {SRC_SF, SRC_HB} src_t;

  state_t             state_q, state_d;
  src_t               src_q, last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [MSG_W-1:0]   msg_q;
  logic               grant_sf, grant_hb;
  logic               last_chunk;
  logic [Ncode-1:0]   code;

  assign last_chunk = (cnt_q == ((src_q == SRC_HB) ? HB_LAST : SF_LAST));

  // Grant only in IDLE; on a tie the source not served last wins
  always_comb begin
    state_d  = state_q;
    grant_sf = 1'b0;
    grant_hb = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.SF_out_v && (!bus.TM_hb_v || last_q == SRC_HB)) begin
          grant_sf = 1'b1;
          state_d  = SEND;
        end else if (bus.TM_hb_v) begin
          grant_hb = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (bus.PC_out_a && last_chunk) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= SRC_SF;
      last_q  <= SRC_HB;
      cnt_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_sf) begin
        src_q  <= SRC_SF;
        last_q <= SRC_SF;
        cnt_q  <= '0;
        msg_q  <= MSG_W'({bus.SF_out_filt_idx, bus.SF_out_state});
      end else if (grant_hb) begin
        src_q  <= SRC_HB;
        last_q <= SRC_HB;
        cnt_q  <= '0;
        msg_q  <= MSG_W'(bus.TM_hb_time);
      end else if (state_q == SEND && bus.PC_out_a && !last_chunk) begin
        cnt_q  <= cnt_q + 1'b1;
        msg_q  <= msg_q >> Nconf;
      end
    end
  end

  // Output word comes straight from registers; PC_out_a only steers the next state
  assign code         = {(src_q == SRC_HB) ? HB_src_id : SF_src_id, cnt_q[1:0]};
  assign bus.PC_out_v = (state_q == SEND);
  assign bus.PC_out_d = (state_q == SEND) ? {code, msg_q[Nconf-1:0]} : '0;
  assign bus.SF_out_a = grant_sf;
  assign bus.TM_hb_a  = grant_hb;

endmodule

// File: tb/tb_pc_upstream_packer.sv
// Bench for pc_upstream_packer: directed vectors plus randomized traffic against a message-level model.
module tb_pc_upstream_packer;

  logic clk = 1'b0;
  logic reset;

  pc_upstream_packer_if bus ();

  pc_upstream_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        s_sfa, s_hba, s_v, s_pa, s_sfv, s_hbv;
  logic [23:0] s_d;

  // Sample outputs on the falling edge, then return just after the next rising edge
  task automatic tick();
    @(negedge clk);
    s_sfa = bus.SF_out_a;
    s_hba = bus.TM_hb_a;
    s_v   = bus.PC_out_v;
    s_pa  = bus.PC_out_a;
    s_d   = bus.PC_out_d;
    s_sfv = bus.SF_out_v;
    s_hbv = bus.TM_hb_v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] model_word(bit hb, logic [47:0] msg, int i);
    logic [5:0] id;
    logic [1:0] ci;
    id = hb ? 6'h11 : 6'h10;
    ci = i[1:0];
    return {id, ci, msg[i*16 +: 16]};
  endfunction

  function automatic logic [47:0] sf_msg(logic [9:0] idx, logic [26:0] st);
    return {11'd0, idx, st};
  endfunction

  task automatic idle_inputs();
    bus.SF_out_v        = 1'b0;
    bus.SF_out_filt_idx = '0;
    bus.SF_out_state    = '0;
    bus.TM_hb_v         = 1'b0;
    bus.TM_hb_time      = '0;
    bus.PC_out_a        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.PC_out_a = 1'b1;
    repeat (2) tick();
    n_cmp++; if (s_v !== 1'b0) begin n_bad++; $display("FAIL reset_v: got %b want 0", s_v); end
    n_cmp++; if (s_d !== 24'h0) begin n_bad++; $display("FAIL reset_d: got %h want 000000", s_d); end
    n_cmp++; if (s_sfa !== 1'b0) begin n_bad++; $display("FAIL reset_sf_a: got %b want 0", s_sfa); end
    n_cmp++; if (s_hba !== 1'b0) begin n_bad++; $display("FAIL reset_hb_a: got %b want 0", s_hba); end
    reset = 1'b1;
    tick();
    n_cmp++; if (s_v !== 1'b0) begin n_bad++; $display("FAIL idle_no_src_v: got %b want 0", s_v); end
  endtask

  task automatic test_single_sf();
    logic [23:0] exp_w [3] = '{24'h40A5A5, 24'h412DA5, 24'h420015};
    logic [23:0] w[$];
    int          wc[$];
    int          hs = -100;
    int          nsfa = 0;
    bus.SF_out_filt_idx = 10'h2A5;
    bus.SF_out_state    = 27'h5A5A5A5;
    bus.SF_out_v        = 1'b1;
    bus.PC_out_a        = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_sfa) begin nsfa++; hs = c; bus.SF_out_v = 1'b0; end
      if (s_v && s_pa) begin w.push_back(s_d); wc.push_back(c); end
    end
    n_cmp++; if (nsfa != 1) begin n_bad++; $display("FAIL sf_a_pulses: got %0d want 1", nsfa); end
    n_cmp++; if (w.size() != 3) begin n_bad++; $display("FAIL sf_word_count: got %0d want 3", w.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= w.size()) begin n_bad++; $display("FAIL sf_word%0d: got none want %h", i, exp_w[i]); end
      else if (w[i] !== exp_w[i] || wc[i] != hs + 1 + i) begin
        n_bad++;
        $display("FAIL sf_word%0d: got %h at cycle %0d want %h at cycle %0d", i, w[i], wc[i], exp_w[i], hs + 1 + i);
      end
    end
  endtask

  task automatic test_single_hb();
    logic [23:0] exp_w [3] = '{24'h449ABC, 24'h455678, 24'h461234};
    logic [23:0] w[$];
    int          wc[$];
    int          hs = -100;
    int          nhba = 0;
    bus.TM_hb_time = 48'h123456789ABC;
    bus.TM_hb_v    = 1'b1;
    bus.PC_out_a   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_hba) begin nhba++; hs = c; bus.TM_hb_v = 1'b0; end
      if (s_v && s_pa) begin w.push_back(s_d); wc.push_back(c); end
    end
    n_cmp++; if (nhba != 1) begin n_bad++; $display("FAIL hb_a_pulses: got %0d want 1", nhba); end
    n_cmp++; if (w.size() != 3) begin n_bad++; $display("FAIL hb_word_count: got %0d want 3", w.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= w.size()) begin n_bad++; $display("FAIL hb_word%0d: got none want %h", i, exp_w[i]); end
      else if (w[i] !== exp_w[i] || wc[i] != hs + 1 + i) begin
        n_bad++;
        $display("FAIL hb_word%0d: got %h at cycle %0d want %h at cycle %0d", i, w[i], wc[i], exp_w[i], hs + 1 + i);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] sb[$];
    int          g_src[$];
    int          g_cyc[$];
    logic [47:0] sfm, hbm;
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.SF_out_filt_idx = 10'h1C3;
    bus.SF_out_state    = 27'h3F0_0F0F;
    bus.TM_hb_time      = 48'hCAFE_F00D_1234;
    sfm = sf_msg(10'h1C3, 27'h3F0_0F0F);
    hbm = 48'hCAFE_F00D_1234;
    bus.SF_out_v = 1'b1;
    bus.TM_hb_v  = 1'b1;
    bus.PC_out_a = 1'b1;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (s_sfa && s_hba) begin
        n_cmp++; n_bad++; $display("FAIL rr_double_grant: got both a at cycle %0d want one", c);
      end
      if (s_sfa) begin g_src.push_back(0); g_cyc.push_back(c); for (int i = 0; i < 3; i++) sb.push_back(model_word(0, sfm, i)); end
      if (s_hba) begin g_src.push_back(1); g_cyc.push_back(c); for (int i = 0; i < 3; i++) sb.push_back(model_word(1, hbm, i)); end
      if (s_v && s_pa) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL rr_word: got %h want none", s_d); end
        else begin
          logic [23:0] e;
          e = sb.pop_front();
          if (s_d !== e) begin n_bad++; $display("FAIL rr_word: got %h want %h", s_d, e); end
        end
      end
      if (c == 24) begin bus.SF_out_v = 1'b0; bus.TM_hb_v = 1'b0; end
    end
    n_cmp++; if (g_src.size() != 7) begin n_bad++; $display("FAIL rr_grants: got %0d want 7", g_src.size()); end
    for (int k = 0; k < g_src.size(); k++) begin
      n_cmp++;
      if (g_src[k] != (k % 2) || g_cyc[k] != 4 * k) begin
        n_bad++;
        $display("FAIL rr_order%0d: got src %0d at cycle %0d want src %0d at cycle %0d", k, g_src[k], g_cyc[k], k % 2, 4 * k);
      end
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rr_drain: got %0d words left want 0", sb.size()); end
  endtask

  task automatic test_random_backpressure();
    logic [23:0] sb[$];
    logic [23:0] prev_d = '0;
    bit          prev_stall = 1'b0;
    bit          last_hb = 1'b1;
    int          granted = 0;
    int          cyc = 0;
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    while (cyc < 20000 && !(granted >= 200 && sb.size() == 0)) begin
      tick();
      cyc++;
      if (s_sfa || s_hba) begin
        n_cmp++;
        if (s_sfa && s_hba) begin n_bad++; $display("FAIL rnd_double_grant: got both a want one"); end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL rnd_grant_in_send: got grant with %0d words pending want 0", sb.size()); end
        if (s_sfv && s_hbv) begin
          n_cmp++;
          if (s_hba !== !last_hb) begin n_bad++; $display("FAIL rnd_rr: got hb_grant=%b want %b", s_hba, !last_hb); end
        end
        if (s_hba) for (int i = 0; i < 3; i++) sb.push_back(model_word(1, bus.TM_hb_time, i));
        else for (int i = 0; i < 3; i++) sb.push_back(model_word(0, sf_msg(bus.SF_out_filt_idx, bus.SF_out_state), i));
        last_hb = s_hba;
        granted++;
      end else if (!s_v && (s_sfv || s_hbv)) begin
        n_cmp++; n_bad++; $display("FAIL rnd_no_grant: got no grant with sf_v=%b hb_v=%b want a grant", s_sfv, s_hbv);
      end
      if (prev_stall) begin
        n_cmp++;
        if (s_v !== 1'b1 || s_d !== prev_d) begin n_bad++; $display("FAIL rnd_hold: got v=%b d=%h want v=1 d=%h", s_v, s_d, prev_d); end
      end
      if (s_v && s_pa) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL rnd_word: got %h want none", s_d); end
        else begin
          logic [23:0] e;
          e = sb.pop_front();
          if (s_d !== e) begin n_bad++; $display("FAIL rnd_word: got %h want %h", s_d, e); end
        end
      end
      prev_stall = s_v && !s_pa;
      prev_d     = s_d;
      if (s_sfa) bus.SF_out_v = 1'b0;
      else if (bus.SF_out_v && $urandom_range(7) == 0) bus.SF_out_v = 1'b0;
      if (s_hba) bus.TM_hb_v = 1'b0;
      else if (bus.TM_hb_v && $urandom_range(7) == 0) bus.TM_hb_v = 1'b0;
      if (granted >= 200) begin
        bus.SF_out_v = 1'b0;
        bus.TM_hb_v  = 1'b0;
      end else begin
        if (!bus.SF_out_v && $urandom_range(2) == 0) begin
          bus.SF_out_filt_idx = 10'($urandom);
          bus.SF_out_state    = 27'($urandom);
          bus.SF_out_v        = 1'b1;
        end
        if (!bus.TM_hb_v && $urandom_range(2) == 0) begin
          bus.TM_hb_time = {16'($urandom), 32'($urandom)};
          bus.TM_hb_v    = 1'b1;
        end
      end
      bus.PC_out_a = 1'($urandom_range(1));
    end
    n_cmp++;
    if (granted < 200 || sb.size() != 0) begin
      n_bad++; $display("FAIL rnd_complete: got %0d grants %0d words pending want >=200 and 0", granted, sb.size());
    end
  endtask

  task automatic test_reset_mid_message();
    logic [23:0] w[$];
    logic [47:0] hbm;
    int          acc = 0;
    int          hs = -1;
    idle_inputs();
    bus.SF_out_filt_idx = 10'h3FF;
    bus.SF_out_state    = 27'h7FF_FFFF;
    bus.SF_out_v        = 1'b1;
    bus.PC_out_a        = 1'b1;
    for (int c = 0; c < 12 && acc < 2; c++) begin
      tick();
      if (s_sfa) bus.SF_out_v = 1'b0;
      if (s_v && s_pa) acc++;
    end
    n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL mid_setup: got %0d chunks want 2", acc); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.PC_out_v !== 1'b0) begin n_bad++; $display("FAIL mid_async_v: got %b want 0", bus.PC_out_v); end
    n_cmp++; if (bus.PC_out_d !== 24'h0) begin n_bad++; $display("FAIL mid_async_d: got %h want 000000", bus.PC_out_d); end
    tick();
    reset = 1'b1;
    hbm = {16'($urandom), 32'($urandom)};
    bus.TM_hb_time = hbm;
    bus.TM_hb_v    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_hba) begin hs = c; bus.TM_hb_v = 1'b0; end
      if (s_v && s_pa) w.push_back(s_d);
    end
    n_cmp++; if (hs != 0) begin n_bad++; $display("FAIL mid_hb_grant: got cycle %0d want 0", hs); end
    n_cmp++; if (w.size() != 3) begin n_bad++; $display("FAIL mid_word_count: got %0d want 3", w.size()); end
    for (int i = 0; i < 3 && i < w.size(); i++) begin
      n_cmp++;
      if (w[i] !== model_word(1, hbm, i)) begin n_bad++; $display("FAIL mid_word%0d: got %h want %h", i, w[i], model_word(1, hbm, i)); end
    end
    n_cmp++;
    if (w.size() == 0 || w[0][23:16] !== 8'h44) begin n_bad++; $display("FAIL mid_first_code: got %h want 44", (w.size() == 0) ? 8'h00 : w[0][23:16]); end
  endtask

  task automatic test_pulse_in_send();
    logic [23:0] w[$];
    logic [47:0] hbm;
    int          nsfa = 0;
    int          pulsed = 0;
    idle_inputs();
    hbm = {16'($urandom), 32'($urandom)};
    bus.TM_hb_time = hbm;
    bus.TM_hb_v    = 1'b1;
    bus.PC_out_a   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_sfa) nsfa++;
      if (s_sfv) pulsed++;
      if (s_v && s_pa) w.push_back(s_d);
      if (s_hba) begin
        bus.TM_hb_v         = 1'b0;
        bus.SF_out_filt_idx = 10'h155;
        bus.SF_out_state    = 27'h2AA_AAAA;
        bus.SF_out_v        = 1'b1;
      end else begin
        bus.SF_out_v = 1'b0;
      end
    end
    n_cmp++; if (pulsed != 1) begin n_bad++; $display("FAIL pulse_setup: got %0d sf_v cycles want 1", pulsed); end
    n_cmp++; if (nsfa != 0) begin n_bad++; $display("FAIL pulse_sf_a: got %0d accepts want 0", nsfa); end
    n_cmp++; if (w.size() != 3) begin n_bad++; $display("FAIL pulse_word_count: got %0d want 3", w.size()); end
    for (int i = 0; i < 3 && i < w.size(); i++) begin
      n_cmp++;
      if (w[i] !== model_word(1, hbm, i)) begin n_bad++; $display("FAIL pulse_word%0d: got %h want %h", i, w[i], model_word(1, hbm, i)); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_sf();
    test_single_hb();
    test_round_robin();
    test_random_backpressure();
    test_reset_mid_message();
    test_pulse_in_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
